// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] ST_RUN         = 2'b00;
    localparam logic [1:0] ST_MC_WAIT     = 2'b01;
    localparam logic [1:0] ST_FENCE_DRAIN = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - operand forward select for one EX source register
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] rs_EX,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic                  reg_write_M,
    input  logic [REG_ADDR_W-1:0] rd_WB,
    input  logic                  reg_write_WB,
    output logic [1:0]            fwd_sel
);

    logic rs_nonzero;
    assign rs_nonzero = (rs_EX != '0);

    // The M-stage result is younger, so it shadows a matching WB write.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_M && rs_nonzero && (rd_M == rs_EX)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_WB && rs_nonzero && (rd_WB == rs_EX)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with MC-op wait and FENCE drain
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int STORE_CNT_W = 2,
    parameter int MC_TIMEOUT  = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  i_rs1Addr_ID,
    input  logic [REG_ADDR_W-1:0]  i_rs2Addr_ID,
    input  logic [REG_ADDR_W-1:0]  i_rs1Addr_EX,
    input  logic [REG_ADDR_W-1:0]  i_rs2Addr_EX,
    input  logic [REG_ADDR_W-1:0]  i_rdAddr_EX,
    input  logic [1:0]             i_result_src_EX,
    input  logic                   i_pcSrc_EX,
    input  logic [REG_ADDR_W-1:0]  i_rdAddr_M,
    input  logic                   i_reg_write_M,
    input  logic [REG_ADDR_W-1:0]  i_rdAddr_WB,
    input  logic                   i_reg_write_WB,
    input  logic                   i_fence_ID,
    input  logic                   i_mc_start_EX,
    input  logic                   i_mc_done,
    input  logic                   i_store_issue,
    input  logic                   i_store_ack,
    output logic                   o_stall_IF,
    output logic                   o_stall_ID,
    output logic                   o_stall_EX,
    output logic                   o_flush_ID,
    output logic                   o_flush_EX,
    output logic                   o_flush_M,
    output logic [1:0]             o_forward_rs1_EX,
    output logic [1:0]             o_forward_rs2_EX,
    output logic                   o_fence_busy,
    output logic [STORE_CNT_W-1:0] o_store_pending,
    output logic                   o_mc_timeout,
    output logic                   o_store_ovf
);

    localparam int MC_CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [MC_CNT_W-1:0]    MC_LAST   = MC_CNT_W'(MC_TIMEOUT - 1);
    localparam logic [STORE_CNT_W-1:0] STORE_MAX = {STORE_CNT_W{1'b1}};

    logic [1:0]             state_q, state_d;
    logic [MC_CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic [STORE_CNT_W-1:0] store_cnt_q, store_cnt_d;
    logic                   store_ovf_q, store_ovf_d;

    logic [1:0] fwd_rs1, fwd_rs2;
    logic       lw_stall;
    logic       mc_go;
    logic       fence_go;
    logic       mc_timeout;

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_EX        (i_rs1Addr_EX),
        .rd_M         (i_rdAddr_M),
        .reg_write_M  (i_reg_write_M),
        .rd_WB        (i_rdAddr_WB),
        .reg_write_WB (i_reg_write_WB),
        .fwd_sel      (fwd_rs1)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_EX        (i_rs2Addr_EX),
        .rd_M         (i_rdAddr_M),
        .reg_write_M  (i_reg_write_M),
        .rd_WB        (i_rdAddr_WB),
        .reg_write_WB (i_reg_write_WB),
        .fwd_sel      (fwd_rs2)
    );

    assign lw_stall = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rdAddr_EX != '0) &&
                      ((i_rdAddr_EX == i_rs1Addr_ID) || (i_rdAddr_EX == i_rs2Addr_ID));

    assign mc_go    = i_mc_start_EX && !i_mc_done;

    // A taken branch squashes the fence; an MC op in EX defers it until MC_WAIT ends.
    assign fence_go = i_fence_ID && !i_pcSrc_EX && !i_mc_start_EX &&
                      ((store_cnt_q != '0) || i_store_issue);

    assign mc_timeout = (state_q == ST_MC_WAIT) && !i_mc_done && (mc_cnt_q == MC_LAST);

    always_comb begin
        store_cnt_d = store_cnt_q;
        store_ovf_d = store_ovf_q;
        case ({i_store_issue, i_store_ack})
            2'b10: begin
                if (store_cnt_q == STORE_MAX) begin
                    store_ovf_d = 1'b1;
                end else begin
                    store_cnt_d = store_cnt_q + STORE_CNT_W'(1);
                end
            end
            2'b01: begin
                if (store_cnt_q != '0) begin
                    store_cnt_d = store_cnt_q - STORE_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // The MC counter includes the RUN cycle in which the op was first seen.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        case (state_q)
            ST_RUN: begin
                mc_cnt_d = '0;
                if (mc_go) begin
                    state_d  = ST_MC_WAIT;
                    mc_cnt_d = MC_CNT_W'(1);
                end else if (fence_go) begin
                    state_d = ST_FENCE_DRAIN;
                end
            end
            ST_MC_WAIT: begin
                if (i_mc_done || mc_timeout) begin
                    state_d  = ST_RUN;
                    mc_cnt_d = '0;
                end else begin
                    mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
                end
            end
            ST_FENCE_DRAIN: begin
                if (store_cnt_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            mc_cnt_q    <= '0;
            store_cnt_q <= '0;
            store_ovf_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            store_cnt_q <= store_cnt_d;
            store_ovf_q <= store_ovf_d;
        end
    end

    always_comb begin
        o_stall_IF       = 1'b0;
        o_stall_ID       = 1'b0;
        o_stall_EX       = 1'b0;
        o_flush_ID       = 1'b0;
        o_flush_EX       = 1'b0;
        o_flush_M        = 1'b0;
        o_forward_rs1_EX = fwd_rs1;
        o_forward_rs2_EX = fwd_rs2;
        o_fence_busy     = 1'b0;
        o_store_pending  = store_cnt_q;
        o_mc_timeout     = mc_timeout;
        o_store_ovf      = store_ovf_q;
        case (state_q)
            ST_RUN: begin
                o_stall_IF = lw_stall || mc_go;
                o_stall_ID = lw_stall || mc_go;
                o_stall_EX = mc_go;
                o_flush_M  = mc_go;
                o_flush_EX = lw_stall || i_pcSrc_EX;
                o_flush_ID = i_pcSrc_EX;
            end
            ST_MC_WAIT: begin
                o_stall_IF = !i_mc_done;
                o_stall_ID = !i_mc_done;
                o_stall_EX = !i_mc_done;
                o_flush_M  = !i_mc_done;
            end
            ST_FENCE_DRAIN: begin
                o_stall_IF   = 1'b1;
                o_stall_ID   = 1'b1;
                o_flush_EX   = 1'b1;
                o_fence_busy = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            o_stall_IF       = 1'b0;
            o_stall_ID       = 1'b0;
            o_stall_EX       = 1'b0;
            o_flush_ID       = 1'b1;
            o_flush_EX       = 1'b1;
            o_flush_M        = 1'b0;
            o_forward_rs1_EX = FWD_RF;
            o_forward_rs2_EX = FWD_RF;
            o_fence_busy     = 1'b0;
            o_store_pending  = '0;
            o_mc_timeout     = 1'b0;
            o_store_ovf      = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_M, rd_WB;
    logic [1:0] result_src_EX;
    logic       pcSrc_EX, reg_write_M, reg_write_WB, fence_ID;
    logic       mc_start_EX, mc_done, store_issue, store_ack;
    logic       stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_M;
    logic [1:0] fwd_rs1, fwd_rs2;
    logic       fence_busy, mc_timeout, store_ovf;
    logic [1:0] store_pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(4), .STORE_CNT_W(2), .MC_TIMEOUT(40)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_rs1Addr_ID     (rs1_ID),
        .i_rs2Addr_ID     (rs2_ID),
        .i_rs1Addr_EX     (rs1_EX),
        .i_rs2Addr_EX     (rs2_EX),
        .i_rdAddr_EX      (rd_EX),
        .i_result_src_EX  (result_src_EX),
        .i_pcSrc_EX       (pcSrc_EX),
        .i_rdAddr_M       (rd_M),
        .i_reg_write_M    (reg_write_M),
        .i_rdAddr_WB      (rd_WB),
        .i_reg_write_WB   (reg_write_WB),
        .i_fence_ID       (fence_ID),
        .i_mc_start_EX    (mc_start_EX),
        .i_mc_done        (mc_done),
        .i_store_issue    (store_issue),
        .i_store_ack      (store_ack),
        .o_stall_IF       (stall_IF),
        .o_stall_ID       (stall_ID),
        .o_stall_EX       (stall_EX),
        .o_flush_ID       (flush_ID),
        .o_flush_EX       (flush_EX),
        .o_flush_M        (flush_M),
        .o_forward_rs1_EX (fwd_rs1),
        .o_forward_rs2_EX (fwd_rs2),
        .o_fence_busy     (fence_busy),
        .o_store_pending  (store_pending),
        .o_mc_timeout     (mc_timeout),
        .o_store_ovf      (store_ovf)
    );

    // Advance one edge, then leave 1ns before new inputs are applied.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_ID = 0; rs2_ID = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0; rd_M = 0; rd_WB = 0;
        result_src_EX = 2'b00; pcSrc_EX = 0; reg_write_M = 0; reg_write_WB = 0;
        fence_ID = 0; mc_start_EX = 0; mc_done = 0; store_issue = 0; store_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        rs1_EX = 4'd5; rd_M = 4'd5; reg_write_M = 1;
        tick(); tick();
        #1;
        total++;
        if ({flush_ID, flush_EX} !== 2'b11) begin
            bad++; $display("FAIL reset_flush got=%b exp=11", {flush_ID, flush_EX});
        end
        total++;
        if ({stall_IF, stall_ID, stall_EX, flush_M, fence_busy, mc_timeout, store_ovf} !== 7'b0) begin
            bad++; $display("FAIL reset_zero got=%b exp=0000000",
                {stall_IF, stall_ID, stall_EX, flush_M, fence_busy, mc_timeout, store_ovf});
        end
        total++;
        if ({fwd_rs1, fwd_rs2, store_pending} !== 6'b0) begin
            bad++; $display("FAIL reset_fwd_cnt got=%b exp=000000", {fwd_rs1, fwd_rs2, store_pending});
        end
        rst = 1;
        idle_inputs();
        tick();
        #1;
        total++;
        if ({flush_ID, flush_EX, fence_busy} !== 3'b000) begin
            bad++; $display("FAIL reset_release got=%b exp=000", {flush_ID, flush_EX, fence_busy});
        end
    endtask

    task automatic test_forward();
        rs1_EX = 4'd5; rd_M = 4'd5; rd_WB = 4'd5; reg_write_M = 1; reg_write_WB = 1;
        #1;
        total++;
        if (fwd_rs1 !== 2'b10) begin bad++; $display("FAIL fwd_m_wins got=%b exp=10", fwd_rs1); end
        rd_M = 4'd0;
        #1;
        total++;
        if (fwd_rs1 !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b exp=01", fwd_rs1); end
        rs1_EX = 4'd0;
        #1;
        total++;
        if (fwd_rs1 !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", fwd_rs1); end
        rs2_EX = 4'd9; rd_M = 4'd9; reg_write_M = 0; rd_WB = 4'd9;
        #1;
        total++;
        if (fwd_rs2 !== 2'b01) begin bad++; $display("FAIL fwd_rs2_nowe_m got=%b exp=01", fwd_rs2); end
        reg_write_WB = 0;
        #1;
        total++;
        if (fwd_rs2 !== 2'b00) begin bad++; $display("FAIL fwd_rs2_none got=%b exp=00", fwd_rs2); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        result_src_EX = 2'b01; rd_EX = 4'd3; rs2_ID = 4'd3; rs1_ID = 4'd7;
        #1;
        total++;
        if ({stall_IF, stall_ID, flush_EX, flush_ID} !== 4'b1110) begin
            bad++; $display("FAIL lw_stall got=%b exp=1110", {stall_IF, stall_ID, flush_EX, flush_ID});
        end
        tick();
        result_src_EX = 2'b00;
        #1;
        total++;
        if ({stall_IF, stall_ID, flush_EX} !== 3'b000) begin
            bad++; $display("FAIL lw_bubble_done got=%b exp=000", {stall_IF, stall_ID, flush_EX});
        end
        result_src_EX = 2'b01; rd_EX = 4'd0; rs2_ID = 4'd0;
        #1;
        total++;
        if ({stall_IF, stall_ID, flush_EX} !== 3'b000) begin
            bad++; $display("FAIL lw_x0 got=%b exp=000", {stall_IF, stall_ID, flush_EX});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_multicycle();
        int errs = 0;
        mc_start_EX = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ({stall_IF, stall_ID, stall_EX, flush_M} !== 4'b1111) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL mc_stall_cycles got=%0d_bad_cycles exp=0", errs); end
        mc_done = 1;
        #1;
        total++;
        if ({stall_IF, stall_ID, stall_EX, flush_M} !== 4'b0000) begin
            bad++; $display("FAIL mc_done_release got=%b exp=0000", {stall_IF, stall_ID, stall_EX, flush_M});
        end
        tick();
        mc_start_EX = 0; mc_done = 0;
        #1;
        total++;
        if ({stall_IF, stall_EX, flush_M, mc_timeout} !== 4'b0000) begin
            bad++; $display("FAIL mc_back_to_run got=%b exp=0000", {stall_IF, stall_EX, flush_M, mc_timeout});
        end
        mc_start_EX = 1; mc_done = 1;
        #1;
        total++;
        if ({stall_IF, stall_EX, flush_M} !== 3'b000) begin
            bad++; $display("FAIL mc_single_cycle got=%b exp=000", {stall_IF, stall_EX, flush_M});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mc_timeout();
        int pulses = 0;
        int pulse_cycle = -1;
        mc_start_EX = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mc_timeout === 1'b1) begin pulses++; pulse_cycle = c; end
            tick();
        end
        mc_start_EX = 0;
        #1;
        if (mc_timeout === 1'b1) pulses++;
        total++;
        if (pulses != 1 || pulse_cycle != 39) begin
            bad++; $display("FAIL mc_timeout_pulse got=%0d_pulses_at_%0d exp=1_at_39", pulses, pulse_cycle);
        end
        total++;
        if ({stall_IF, stall_EX, flush_M} !== 3'b000) begin
            bad++; $display("FAIL mc_timeout_exit got=%b exp=000", {stall_IF, stall_EX, flush_M});
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fence();
        store_issue = 1;
        tick(); tick();
        store_issue = 0;
        fence_ID = 1;
        tick();
        #1;
        total++;
        if ({fence_busy, stall_IF, stall_ID, flush_EX} !== 4'b1111 || store_pending !== 2'd2) begin
            bad++; $display("FAIL fence_drain got=%b/%0d exp=1111/2",
                {fence_busy, stall_IF, stall_ID, flush_EX}, store_pending);
        end
        store_ack = 1;
        tick();
        #1;
        total++;
        if (fence_busy !== 1'b1 || store_pending !== 2'd1) begin
            bad++; $display("FAIL fence_one_ack got=%b/%0d exp=1/1", fence_busy, store_pending);
        end
        tick();
        store_ack = 0;
        #1;
        total++;
        if (fence_busy !== 1'b0 || store_pending !== 2'd0 || stall_IF !== 1'b0) begin
            bad++; $display("FAIL fence_exit got=%b/%0d/%b exp=0/0/0", fence_busy, store_pending, stall_IF);
        end
        fence_ID = 0;
        store_issue = 1;
        tick();
        store_issue = 0;
        fence_ID = 1; pcSrc_EX = 1;
        #1;
        total++;
        if ({flush_ID, flush_EX} !== 2'b11) begin
            bad++; $display("FAIL fence_squash_flush got=%b exp=11", {flush_ID, flush_EX});
        end
        tick();
        fence_ID = 0; pcSrc_EX = 0;
        #1;
        total++;
        if (fence_busy !== 1'b0 || store_pending !== 2'd1) begin
            bad++; $display("FAIL fence_squash_nodrain got=%b/%0d exp=0/1", fence_busy, store_pending);
        end
        store_ack = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_counter_edges();
        store_issue = 1;
        tick(); tick(); tick();
        #1;
        total++;
        if (store_pending !== 2'd3 || store_ovf !== 1'b0) begin
            bad++; $display("FAIL cnt_fill got=%0d/%b exp=3/0", store_pending, store_ovf);
        end
        tick();
        #1;
        total++;
        if (store_pending !== 2'd3 || store_ovf !== 1'b1) begin
            bad++; $display("FAIL cnt_overflow got=%0d/%b exp=3/1", store_pending, store_ovf);
        end
        store_ack = 1;
        tick();
        #1;
        total++;
        if (store_pending !== 2'd3) begin
            bad++; $display("FAIL cnt_issue_ack got=%0d exp=3", store_pending);
        end
        store_issue = 0;
        tick(); tick(); tick(); tick();
        #1;
        total++;
        if (store_pending !== 2'd0 || store_ovf !== 1'b1) begin
            bad++; $display("FAIL cnt_ack_at_zero got=%0d/%b exp=0/1", store_pending, store_ovf);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        store_issue = 1;
        tick(); tick();
        store_issue = 0;
        fence_ID = 1;
        tick();
        #1;
        total++;
        if (fence_busy !== 1'b1 || store_pending !== 2'd2) begin
            bad++; $display("FAIL drain_setup got=%b/%0d exp=1/2", fence_busy, store_pending);
        end
        fence_ID = 0;
        rst = 0;
        #1;
        total++;
        if ({flush_ID, flush_EX, fence_busy, stall_IF} !== 4'b1100) begin
            bad++; $display("FAIL drain_in_reset got=%b exp=1100", {flush_ID, flush_EX, fence_busy, stall_IF});
        end
        tick();
        rst = 1;
        #1;
        total++;
        if (fence_busy !== 1'b0 || store_pending !== 2'd0 || store_ovf !== 1'b0 || flush_EX !== 1'b0) begin
            bad++; $display("FAIL drain_after_reset got=%b/%0d/%b/%b exp=0/0/0/0",
                fence_busy, store_pending, store_ovf, flush_EX);
        end
        tick();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_mc_timeout();
        test_fence();
        test_counter_edges();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
